axis_frame_player: RTL and testbench



---
 rtl/axis_frame_player_pkg.sv | 26 ++
 rtl/axis_frame_player_buf.sv | 37 +++
 rtl/axis_frame_player.sv | 207 ++++++++++++++++++++
 tb/tb_axis_frame_player.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_player_pkg.sv
// axis_frame_player_pkg
// Purpose: shared definitions for the frame player: FSM state encoding,
//          sample-width and address-width helpers, frame-counter width.
package axis_frame_player_pkg;

  // Playback controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Width of the frame counter and of the num_frames request.
  localparam int FRAME_CNT_W = 16;

  // Bits per AXI-Stream beat: one component, or an {imag,real} pair.
  function automatic int calc_dw(input int int_bits, input int frac_bits, input int cplx);
    return (int_bits + frac_bits) * ((cplx != 0) ? 2 : 1);
  endfunction

  // Sample-index width for a frame of n samples (n is a power of 2).
  function automatic int calc_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/axis_frame_player_buf.sv
// axis_frame_player_buf
// Purpose: simple dual-port sample store, one write port and one read port
//          with a registered read. rd_data holds its value while rd_en=0,
//          so the reader can park a fetched sample under back-pressure.
//          Contents are never reset.
// Ports:
//   clk                         clock
//   wr_en / wr_addr / wr_data   write port
//   rd_en / rd_addr             read request (data appears next cycle)
//   rd_data                     registered read data
module axis_frame_player_buf
  import axis_frame_player_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_frame_player.sv
// axis_frame_player
// Purpose: plays a RAM-resident frame of N samples out of an AXI4-Stream
//          master, once per frame, for num_frames frames (0 = until stop).
//          Buffer writes are accepted only while idle.
// Ports:
//   axis_clk, axis_reset        clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data     buffer load port (ignored while busy)
//   start, stop, num_frames     playback control
//   busy, done                  status (done pulses once at playback end)
//   axis_tvalid/tready/tlast/tdata  AXI4-Stream master
//   rate_div                    only with AXIS_FRAME_PLAYER_THROTTLE_EN: a new
//                               beat is presented at most every rate_div+1 cycles
// Optional feature macro: AXIS_FRAME_PLAYER_THROTTLE_EN
module axis_frame_player
  import axis_frame_player_pkg::*;
#(
  parameter int P_FIXED_INT      = 2,
  parameter int P_FIXED_FRAC     = 14,
  parameter int P_FFT_NUM_SAMPLE = 256,
  parameter int P_COMPLEX        = 1
) (
  input  logic                                                axis_clk,
  input  logic                                                axis_reset,
  input  logic                                                wr_en,
  input  logic [calc_aw(P_FFT_NUM_SAMPLE)-1:0]                wr_addr,
  input  logic [calc_dw(P_FIXED_INT,P_FIXED_FRAC,P_COMPLEX)-1:0] wr_data,
  input  logic                                                start,
  input  logic                                                stop,
  input  logic [FRAME_CNT_W-1:0]                              num_frames,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                axis_tvalid,
  input  logic                                                axis_tready,
  output logic                                                axis_tlast,
`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
  input  logic [15:0]                                         rate_div,
`endif
  output logic [calc_dw(P_FIXED_INT,P_FIXED_FRAC,P_COMPLEX)-1:0] axis_tdata
);

  localparam int DW = calc_dw(P_FIXED_INT, P_FIXED_FRAC, P_COMPLEX);
  localparam int AW = calc_aw(P_FFT_NUM_SAMPLE);
  localparam logic [AW-1:0] LAST_IDX = AW'(P_FFT_NUM_SAMPLE - 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;       // next index to fetch
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;   // frames fully fetched
  logic [FRAME_CNT_W-1:0] num_frames_q, num_frames_d; // request latched at start
  logic                   stop_req_q, stop_req_d;
  logic                   pend_q, pend_d;             // RAM output holds an unsent sample
  logic                   pend_last_q, pend_last_d;   // ... and it is index N-1
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic                   done_q, done_d;

  logic          rd_en;
  logic [DW-1:0] buf_rd_data;
  logic          rate_ok;
  logic          load;
  logic          slot_free;
  logic          stop_any;

`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
  logic [15:0] rate_cnt_q, rate_cnt_d;
  assign rate_ok = (rate_cnt_q == 16'd0);
`else
  assign rate_ok = 1'b1;
`endif

  axis_frame_player_buf #(
    .DEPTH (P_FFT_NUM_SAMPLE),
    .WIDTH (DW),
    .AW    (AW)
  ) u_buf (
    .clk     (axis_clk),
    .wr_en   (wr_en && (state_q == IDLE)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_data (buf_rd_data)
  );

  // The parked RAM sample moves to the output register whenever that
  // register is empty or being drained this cycle. A new fetch is allowed
  // whenever the RAM output slot will be free after this edge, which keeps
  // one beat per cycle without ever overwriting an unsent sample.
  assign load      = pend_q && (!tvalid_q || axis_tready) && rate_ok;
  assign slot_free = !pend_q || load;
  assign stop_any  = stop_req_q || stop;

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    frame_cnt_d  = frame_cnt_q;
    num_frames_d = num_frames_q;
    stop_req_d   = stop_req_q;
    pend_d       = pend_q;
    pend_last_d  = pend_last_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    done_d       = 1'b0;
    rd_en        = 1'b0;
`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
    rate_cnt_d   = rate_cnt_q;
    if (load)                    rate_cnt_d = rate_div;
    else if (rate_cnt_q != 16'd0) rate_cnt_d = rate_cnt_q - 16'd1;
`endif

    // Output register
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = buf_rd_data;
      tlast_d  = pend_last_q;
    end else if (axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    if (load) pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Fetch index 0 in the start cycle itself so the first beat is
        // valid two cycles after start. A simultaneous stop is ignored.
        if (start) begin
          state_d      = PLAY;
          rd_en        = 1'b1;
          rd_addr_d    = rd_addr_q + AW'(1);
          frame_cnt_d  = '0;
          num_frames_d = num_frames;
          stop_req_d   = 1'b0;
        end
      end
      PLAY: begin
        stop_req_d = stop_any;
        if (stop_any && (rd_addr_q == '0)) begin
          // Frame boundary with nothing of the next frame fetched: end now.
          state_d = FLUSH;
        end else if (slot_free) begin
          rd_en     = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
          if (rd_addr_q == LAST_IDX) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            if (stop_any || ((num_frames_q != '0) && (frame_cnt_d == num_frames_q)))
              state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // No more fetches; wait until parked and registered beats are gone.
        if (!pend_q && !tvalid_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_en) begin
      pend_d      = 1'b1;
      pend_last_d = (rd_addr_q == LAST_IDX);
    end
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      frame_cnt_q  <= '0;
      num_frames_q <= '0;
      stop_req_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      done_q       <= 1'b0;
`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
      rate_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      frame_cnt_q  <= frame_cnt_d;
      num_frames_q <= num_frames_d;
      stop_req_q   <= stop_req_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      done_q       <= done_d;
`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
      rate_cnt_q   <= rate_cnt_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign axis_tvalid = tvalid_q;
  assign axis_tlast  = tlast_q;
  assign axis_tdata  = tdata_q;

endmodule

// File: tb/tb_axis_frame_player.sv
// tb_axis_frame_player
// Purpose: self-checking bench for axis_frame_player (default parameters).
//          Expected beats come from a plain array model of the buffer:
//          beat j of a run carries buffer[j mod N], tlast when j mod N = N-1.
module tb_axis_frame_player;
  import axis_frame_player_pkg::*;

  localparam int N  = 256;
  localparam int DW = calc_dw(2, 14, 1);
  localparam int AW = calc_aw(N);
`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
  localparam int SPACING = 4;
`else
  localparam int SPACING = 1;
`endif

  logic          clk = 1'b0;
  logic          axis_reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   num_frames = '0;
  logic          busy, done;
  logic          axis_tvalid, axis_tlast;
  logic          axis_tready = 1'b0;
  logic [DW-1:0] axis_tdata;
`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
  logic [15:0]   rate_div = 16'd3;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] buf_model [N];

  always #5 clk = ~clk;

  axis_frame_player dut (
    .axis_clk    (clk),
    .axis_reset  (axis_reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .stop        (stop),
    .num_frames  (num_frames),
    .busy        (busy),
    .done        (done),
    .axis_tvalid (axis_tvalid),
    .axis_tready (axis_tready),
    .axis_tlast  (axis_tlast),
`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
    .rate_div    (rate_div),
`endif
    .axis_tdata  (axis_tdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_buf(input bit random_data);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = random_data ? DW'($urandom) : {i[15:0], i[15:0]};
      buf_model[i] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One playback run. stop_beat / reset_beat / poke_beat < 0 disable that event.
  task automatic play(input string name, input int k, input int ready_pct,
                      input int stop_beat, input int reset_beat, input int poke_beat,
                      input int exp_beats, input bit start_with_stop);
    int beats = 0, dones = 0, cyc = 0, last_hs = -1, after = 0;
    bit finished = 0, stop_sent = 0, poked = 0, was_reset = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    int idx;

    @(negedge clk);
    num_frames = 16'(k);
    start      = 1'b1;
    stop       = start_with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check({name, "_busy_on"}, busy, 1);
    check({name, "_lat1_tvalid"}, axis_tvalid, 0);

    while (!finished && cyc < 20000) begin
      if (reset_beat >= 0 && beats == reset_beat) begin
        #1 axis_reset = 1'b1;
        #1;
        check({name, "_rst_tvalid"}, axis_tvalid, 0);
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_tlast"}, axis_tlast, 0);
        @(negedge clk);
        axis_reset = 1'b0;
        was_reset  = 1;
        finished   = 1;
      end else begin
        axis_tready = ($urandom_range(0, 99) < ready_pct);
        if (cyc == 1) check({name, "_lat2_tvalid"}, axis_tvalid, 1);
        if (prev_stall) begin
          check({name, "_stall_valid"}, axis_tvalid, 1);
          check({name, "_stall_data"}, axis_tdata, prev_data);
          check({name, "_stall_last"}, axis_tlast, prev_last);
        end
        if (axis_tvalid && axis_tready) begin
          idx = beats % N;
          check({name, "_data"}, axis_tdata, buf_model[idx]);
          check({name, "_tlast"}, axis_tlast, (idx == N - 1));
          if (ready_pct == 100 && last_hs >= 0)
            check({name, "_spacing"}, cyc - last_hs, SPACING);
          last_hs = cyc;
          beats++;
        end
        prev_stall = axis_tvalid && !axis_tready;
        prev_data  = axis_tdata;
        prev_last  = axis_tlast;
        if (done) dones++;
        if (dones > 0) after++;
        if (after == 4) finished = 1;

        stop = 1'b0;
        if (stop_beat >= 0 && beats == stop_beat && !stop_sent) begin
          stop = 1'b1;
          stop_sent = 1;
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (poke_beat >= 0 && beats == poke_beat && !poked) begin
          wr_en   = 1'b1;
          wr_addr = AW'(5);
          wr_data = DW'(32'hDEADBEEF);
          start   = 1'b1;
          poked   = 1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    stop  = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    axis_tready = 1'b0;

    check({name, "_no_timeout"}, finished, 1);
    check({name, "_beats"}, beats, exp_beats);
    if (!was_reset) begin
      check({name, "_done_pulses"}, dones, 1);
      check({name, "_busy_after"}, busy, 0);
      check({name, "_tvalid_after"}, axis_tvalid, 0);
    end
    $display("run %s: frames=%0d ready=%0d%% beats=%0d done_pulses=%0d cycles=%0d",
             name, k, ready_pct, beats, dones, cyc);
  endtask

  initial begin
    #2;
    check("reset_tvalid", axis_tvalid, 0);
    check("reset_tlast", axis_tlast, 0);
    check("reset_tdata", axis_tdata, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (3) @(negedge clk);
    axis_reset = 1'b0;

    load_buf(1'b0);
    play("ramp_1frame", 1, 100, -1, -1, -1, 256, 1'b0);

    load_buf(1'b1);
    play("rand_3frames", 3, 50, -1, -1, -1, 768, 1'b0);
    play("cont_stop", 0, 100, 356, -1, -1, 512, 1'b0);
    play("write_in_play", 1, 100, -1, -1, 50, 256, 1'b0);
    play("after_write", 1, 70, -1, -1, -1, 256, 1'b0);
    play("reset_mid", 0, 100, -1, 40, -1, 40, 1'b0);
    play("after_reset", 1, 100, -1, -1, -1, 256, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
